// File: rtl/endec_job_scheduler_pkg.sv
// Shared constants for the endec codec and its job scheduler.
// Frame and result widths are derived from the codec field sizes.
package endec_job_scheduler_pkg;

  localparam int unsigned CFG_W    = 64;
  localparam int unsigned ENC_W    = 576;
  localparam int unsigned DEC_W    = 128;
  localparam int unsigned FRAME_W  = CFG_W + ENC_W;  // 640
  localparam int unsigned RESULT_W = DEC_W + ENC_W;  // 704

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StRun,
    StResp
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid channel strictly after last_grant,
// wrapping around, as a one-hot vector plus its index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((32'(last_grant) + i) % NUM_REQ);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/endec_job_scheduler.sv
// Arbitrates job frames from several requesters onto a single endec core,
// sequences core reset/enable, and returns results with a timeout fallback.
module endec_job_scheduler
  import endec_job_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 4096,
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*FRAME_W-1:0] req_frame_flat,
  output logic                       core_rst,
  output logic                       core_en,
  output logic [FRAME_W-1:0]         core_frame,
  input  logic                       core_enc_done,
  input  logic                       core_dec_done,
  input  logic [ENC_W-1:0]           core_enc_data,
  input  logic [DEC_W-1:0]           core_dec_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [RESULT_W-1:0]        rsp_data,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       rsp_timeout,
  output logic                       busy
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  sched_state_e        state_q;
  logic [ID_W-1:0]     last_grant_q;
  logic [TIMER_W-1:0]  timer_q;
  logic                flush_seen_q;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic [FRAME_W-1:0]  sel_frame;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .valid     (req_valid),
    .last_grant(last_grant_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_frame = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) sel_frame = req_frame_flat[k*FRAME_W +: FRAME_W];
    end
  end

  // Accept is offered only while idle and out of reset, so no job is accepted and then dropped.
  assign req_ready = (state_q == StIdle && rst_n) ? grant : '0;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      timer_q      <= '0;
      flush_seen_q <= 1'b0;
      core_rst     <= 1'b0;
      core_en      <= 1'b0;
      core_frame   <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= '0;
      rsp_timeout  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            core_frame   <= sel_frame;
            rsp_id       <= grant_idx;
            last_grant_q <= grant_idx;
            flush_seen_q <= 1'b0;
            state_q      <= StFlush;
          end
        end
        StFlush: begin
          // Hold the core in reset for two cycles minimum and until stale done flags clear.
          flush_seen_q <= 1'b1;
          if (flush_seen_q && !core_enc_done && !core_dec_done) begin
            core_rst <= 1'b1;
            core_en  <= 1'b1;
            timer_q  <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (core_enc_done && core_dec_done) begin
            rsp_data    <= {core_dec_data, core_enc_data};
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            core_rst    <= 1'b0;
            core_en     <= 1'b0;
            state_q     <= StResp;
          end else if (timer_q == TIMER_W'(TIMEOUT_CYC - 1)) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            core_rst    <= 1'b0;
            core_en     <= 1'b0;
            state_q     <= StResp;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_endec_job_scheduler.sv
// Directed bench for endec_job_scheduler: a default-timeout instance for the main
// scenarios and a 16-cycle-timeout instance for the timeout boundary.
module tb_endec_job_scheduler;

  logic          sys_clk;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1279:0] req_frame_flat;
  logic          core_enc_done, core_dec_done;
  logic [575:0]  core_enc_data;
  logic [127:0]  core_dec_data;
  logic          rsp_ready;

  logic [1:0]    req_ready, req_ready_t;
  logic          core_rst, core_en, core_rst_t, core_en_t;
  logic [639:0]  core_frame, core_frame_t;
  logic          rsp_valid, rsp_valid_t, rsp_timeout, rsp_timeout_t, busy, busy_t;
  logic [703:0]  rsp_data, rsp_data_t;
  logic [0:0]    rsp_id, rsp_id_t;

  logic [639:0]  frame_a, frame_b;
  logic [575:0]  enc_a, enc_b;
  logic [127:0]  dec_a, dec_b;
  logic [703:0]  exp_a, exp_b;
  logic [1:0]    exp_grant [4];
  logic [0:0]    exp_id [4];

  int errors = 0;
  int checks = 0;

  endec_job_scheduler dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_frame_flat(req_frame_flat), .core_rst(core_rst), .core_en(core_en),
    .core_frame(core_frame), .core_enc_done(core_enc_done), .core_dec_done(core_dec_done),
    .core_enc_data(core_enc_data), .core_dec_data(core_dec_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  endec_job_scheduler #(.NUM_REQ(2), .TIMEOUT_CYC(16)) dut_t (
    .sys_clk(sys_clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_t),
    .req_frame_flat(req_frame_flat), .core_rst(core_rst_t), .core_en(core_en_t),
    .core_frame(core_frame_t), .core_enc_done(core_enc_done), .core_dec_done(core_dec_done),
    .core_enc_data(core_enc_data), .core_dec_data(core_dec_data), .rsp_valid(rsp_valid_t),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data_t), .rsp_id(rsp_id_t),
    .rsp_timeout(rsp_timeout_t), .busy(busy_t)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_done(input logic v);
    core_enc_done = v;
    core_dec_done = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    set_done(1'b0);
    rsp_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL rst_core_rst got=%b exp=0", core_rst); end
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL rst_core_en got=%b exp=0", core_en); end
    checks++; if (core_frame !== '0) begin errors++; $display("FAIL rst_core_frame got=%h exp=0", core_frame); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rst_rsp_id got=%b exp=0", rsp_id); end
    checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_rsp_timeout got=%b exp=0", rsp_timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_job();
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL sj_grant got=%b exp=01", req_ready); end
    cyc();
    req_valid = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL sj_ready_pulse got=%b exp=00", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sj_busy got=%b exp=1", busy); end
    checks++; if (core_frame !== frame_a) begin errors++; $display("FAIL sj_frame got=%h exp=%h", core_frame, frame_a); end
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL sj_en_flush1 got=%b exp=0", core_en); end
    cyc();
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL sj_en_flush2 got=%b exp=0", core_en); end
    cyc();
    checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL sj_en_latency got=%b exp=1", core_en); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL sj_core_rst got=%b exp=1", core_rst); end
    rsp_ready = 1'b1;  // must be ignored outside RESP
    cyc();
    rsp_ready = 1'b0;
    checks++; if (core_en !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL sj_rsp_ready_ignored en=%b valid=%b exp en=1 valid=0", core_en, rsp_valid); end
    repeat (48) cyc();
    set_done(1'b1);
    cyc();
    set_done(1'b0);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL sj_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== exp_a) begin errors++; $display("FAIL sj_rsp_data got=%h exp=%h", rsp_data, exp_a); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL sj_rsp_id got=%b exp=0", rsp_id); end
    checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL sj_rsp_timeout got=%b exp=0", rsp_timeout); end
    checks++; if (core_en !== 1'b0 || core_rst !== 1'b0) begin errors++; $display("FAIL sj_core_drop en=%b rst=%b exp 0 0", core_en, core_rst); end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sj_idle valid=%b busy=%b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_contention();
    do_reset();
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (req_ready !== exp_grant[j]) begin errors++; $display("FAIL ct_grant%0d got=%b exp=%b", j, req_ready, exp_grant[j]); end
      cyc();
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL ct_holdoff%0d got=%b exp=00", j, req_ready); end
      cyc();
      cyc();
      set_done(1'b1);
      cyc();
      set_done(1'b0);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id[j]) begin errors++; $display("FAIL ct_rsp%0d valid=%b id=%b exp valid=1 id=%b", j, rsp_valid, rsp_id, exp_id[j]); end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_timeout();
    do_reset();
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready_t !== 2'b10) begin errors++; $display("FAIL to_grant_wrap got=%b exp=10", req_ready_t); end
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    checks++; if (core_en_t !== 1'b1) begin errors++; $display("FAIL to_run_start got=%b exp=1", core_en_t); end
    repeat (15) cyc();
    checks++; if (core_en_t !== 1'b1 || rsp_valid_t !== 1'b0) begin errors++; $display("FAIL to_run16 en=%b valid=%b exp en=1 valid=0", core_en_t, rsp_valid_t); end
    cyc();
    checks++; if (rsp_valid_t !== 1'b1) begin errors++; $display("FAIL to_rsp_valid got=%b exp=1", rsp_valid_t); end
    checks++; if (rsp_timeout_t !== 1'b1) begin errors++; $display("FAIL to_flag got=%b exp=1", rsp_timeout_t); end
    checks++; if (rsp_data_t !== '0) begin errors++; $display("FAIL to_data got=%h exp=0", rsp_data_t); end
    checks++; if (rsp_id_t !== 1'b1) begin errors++; $display("FAIL to_id got=%b exp=1", rsp_id_t); end
    checks++; if (core_en_t !== 1'b0) begin errors++; $display("FAIL to_core_drop got=%b exp=0", core_en_t); end
    // Done on the final timer cycle must win over the timeout.
    do_reset();
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    repeat (15) cyc();
    set_done(1'b1);
    cyc();
    set_done(1'b0);
    checks++; if (rsp_valid_t !== 1'b1 || rsp_timeout_t !== 1'b0) begin errors++; $display("FAIL to_done_wins valid=%b to=%b exp valid=1 to=0", rsp_valid_t, rsp_timeout_t); end
    checks++; if (rsp_data_t !== exp_a) begin errors++; $display("FAIL to_done_data got=%h exp=%h", rsp_data_t, exp_a); end
    do_reset();
  endtask

  task automatic test_stale_done();
    do_reset();
    core_enc_done = 1'b1;
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    for (int k = 0; k < 5; k++) begin
      checks++; if (core_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sd_hold%0d en=%b busy=%b exp en=0 busy=1", k, core_en, busy); end
      cyc();
    end
    core_enc_done = 1'b0;
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL sd_fall_cycle got=%b exp=0", core_en); end
    cyc();
    checks++; if (core_en !== 1'b1 || core_rst !== 1'b1) begin errors++; $display("FAIL sd_run en=%b rst=%b exp 1 1", core_en, core_rst); end
    set_done(1'b1);
    cyc();
    set_done(1'b0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    core_enc_data = enc_b;
    core_dec_data = dec_b;
    set_done(1'b1);
    cyc();
    set_done(1'b0);
    core_enc_data = enc_a;
    core_dec_data = dec_a;
    req_valid = 2'b11;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin errors++; $display("FAIL bp_valid%0d valid=%b id=%b exp valid=1 id=0", k, rsp_valid, rsp_id); end
      checks++; if (rsp_data !== exp_b) begin errors++; $display("FAIL bp_data%0d got=%h exp=%h", k, rsp_data, exp_b); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got=%b exp=00", k, req_ready); end
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release valid=%b busy=%b exp 0 0", rsp_valid, busy); end
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant got=%b exp=10", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_run();
    // last grant is channel 0 here, so both-valid picks channel 1 first
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mr_first_grant got=%b exp=10", req_ready); end
    cyc();
    cyc();
    cyc();
    checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL mr_run got=%b exp=1", core_en); end
    repeat (19) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    checks++; if (core_en !== 1'b0 || core_rst !== 1'b0) begin errors++; $display("FAIL mr_core en=%b rst=%b exp 0 0", core_en, core_rst); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mr_state valid=%b busy=%b exp 0 0", rsp_valid, busy); end
    checks++; if (core_frame !== '0 || rsp_data !== '0) begin errors++; $display("FAIL mr_regs frame=%h data=%h exp 0", core_frame, rsp_data); end
    checks++; if (rsp_id !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL mr_rsp id=%b to=%b exp 0 0", rsp_id, rsp_timeout); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mr_regrant got=%b exp=01", req_ready); end
    cyc();
    req_valid = 2'b00;
    checks++; if (core_frame !== frame_a || busy !== 1'b1) begin errors++; $display("FAIL mr_reframe busy=%b frame=%h exp=%h", busy, core_frame, frame_a); end
    do_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    core_enc_done = 1'b0;
    core_dec_done = 1'b0;
    frame_a = {20{32'hA5C3_0F1E}};
    frame_b = {20{32'h1234_5678}};
    enc_a = {18{32'hC0DE_0001}};
    dec_a = {4{32'hDEC0_0002}};
    enc_b = {18{32'h5EED_7003}};
    dec_b = {4{32'h0BAD_F004}};
    exp_a = {dec_a, enc_a};
    exp_b = {dec_b, enc_b};
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
    req_frame_flat = {frame_b, frame_a};
    core_enc_data = enc_a;
    core_dec_data = dec_a;

    test_reset();
    test_single_job();
    test_contention();
    test_timeout();
    test_stale_done();
    test_backpressure();
    test_reset_mid_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
